// File: rtl/instr_fetch_latch.sv
// Fetch-side instruction register: issues one memory read per accepted fetch
// request, latches the returned instruction and exposes its decoded fields.
module instr_fetch_latch #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [15:0] pc_in,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [15:0] ir_out,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [7:0]  imm8,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // Handshake: fetch_req is a request that is accepted only at an edge where
  // the FSM is in IDLE or DONE (never queued); mem_rvalid qualifies mem_rdata
  // and is honoured only in REQ or WAIT; ir_valid is a one-cycle strobe that
  // marks the cycle in which a freshly latched ir_out is first presented.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (fetch_req) begin
          addr_d  = pc_in;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_rvalid) begin
          ir_d    = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d   = 8'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Returned data takes priority over a timeout in the same cycle.
        if (mem_rvalid) begin
          ir_d    = mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          ir_d    = NOP_INSTR;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      ir_q    <= 16'h0000;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state_q == S_REQ);
  assign ir_valid  = (state_q == S_DONE);
  assign busy      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign fetch_err = err_q;
  assign state_dbg = state_q;

  assign ir_out = ir_q;
  assign opcode = ir_q[15:12];
  assign rd     = ir_q[11:8];
  assign rs     = ir_q[7:4];
  assign imm8   = ir_q[7:0];

endmodule

// File: tb/tb_instr_fetch_latch.sv
// Directed bench for instr_fetch_latch: drivers push expected instructions
// into a queue, a negedge monitor pops and compares on every ir_valid.
module tb_instr_fetch_latch;

  localparam int W = 25;  // {instr[15:0], err, latency[7:0]}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] ir_out;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [7:0]  imm8;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  instr_fetch_latch #(.TIMEOUT(15), .NOP_INSTR(16'h0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .pc_in      (pc_in),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ir_out     (ir_out),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .imm8       (imm8),
    .ir_valid   (ir_valid),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int last_acc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && ir_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ir_valid", 32'(ir_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ir_out",    32'(ir_out),    32'(mon_e[24:9]));
        chk("fetch_err", 32'(fetch_err), 32'(mon_e[8]));
        chk("latency",   32'(cyc - last_acc + 1), 32'(mon_e[7:0]));
        chk("opcode",    32'(opcode),    32'(mon_e[24:21]));
        chk("rd",        32'(rd),        32'(mon_e[20:17]));
        chk("rs",        32'(rs),        32'(mon_e[16:13]));
        chk("imm8",      32'(imm8),      32'(mon_e[16:9]));
      end
    end
  end

  // One fetch: k wait cycles before data, or a timeout (no data at all).
  // poke pulses fetch_req with a different pc mid-WAIT; hold keeps fetch_req high.
  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] data, input int k,
                          input bit timeout, input bit poke, input bit hold);
    int ncyc;
    int busy_n;
    int rd_n;
    ncyc   = timeout ? 16 : k + 1;
    busy_n = 0;
    rd_n   = 0;
    fetch_req = 1'b1;
    pc_in     = pc;
    tick();
    last_acc = cyc;
    exp_q.push_back({timeout ? 16'h0000 : data, timeout, 8'(ncyc + 1)});
    for (int c = 0; c < ncyc; c++) begin
      fetch_req  = hold || (poke && c == 2);
      pc_in      = (poke && c == 2) ? 16'hDEAD : pc;
      mem_rvalid = !timeout && (c == k);
      mem_rdata  = mem_rvalid ? data : ~data;
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_rd_en) rd_n++;
      if (c == 0) begin
        chk("req_state",     32'(state_dbg), 32'(ST_REQ));
        chk("req_mem_addr",  32'(mem_addr),  32'(pc));
        chk("req_err_clear", 32'(fetch_err), 32'd0);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    fetch_req  = hold;
    chk("busy_cycles",  32'(busy_n), 32'(ncyc));
    chk("rd_en_cycles", 32'(rd_n),   32'd1);
    chk("addr_held",    32'(mem_addr), 32'(pc));
  endtask

  initial begin
    reset_n = 1'b0; fetch_req = 1'b0; pc_in = 16'h0; mem_rdata = 16'h0; mem_rvalid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ir_out",    32'(ir_out),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_rd_en",     32'(mem_rd_en), 32'd0);
    chk("rst_ir_valid",  32'(ir_valid),  32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_state",     32'(state_dbg), 32'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // zero-wait fetch
    do_fetch(16'h0040, 16'h3A5C, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("zw_opcode", 32'(opcode), 32'h3);
    chk("zw_rd",     32'(rd),     32'hA);
    chk("zw_rs",     32'(rs),     32'h5);
    chk("zw_imm8",   32'(imm8),   32'h5C);
    chk("zw_rd_en_done", 32'(mem_rd_en), 32'd0);
    tick();

    // three wait states, with an ignored fetch_req mid-WAIT
    do_fetch(16'h0082, 16'h71FE, 3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ws_imm8", 32'(imm8),      32'hFE);
    chk("ws_err",  32'(fetch_err), 32'd0);
    tick();

    // timeout, then sticky error in IDLE
    do_fetch(16'h00C0, 16'h5555, 0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    chk("to_ir_nop",     32'(ir_out),    32'h0000);
    chk("to_idle",       32'(state_dbg), 32'(ST_IDLE));
    tick();

    // data arriving on the very cycle the counter hits TIMEOUT wins
    do_fetch(16'h00C2, 16'hC0DE, 15, 1'b0, 1'b0, 1'b0);
    tick();

    // back-to-back with fetch_req held high
    do_fetch(16'h0100, 16'h1111, 0, 1'b0, 1'b0, 1'b1);
    do_fetch(16'h0102, 16'h2222, 0, 1'b0, 1'b0, 1'b1);
    fetch_req = 1'b0;
    tick();

    // stray rvalid in IDLE
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hBEEF;
    tick();
    tick();
    @(negedge clk);
    chk("stray_ir_out",   32'(ir_out),    32'h2222);
    chk("stray_ir_valid", 32'(ir_valid),  32'd0);
    chk("stray_state",    32'(state_dbg), 32'(ST_IDLE));
    mem_rvalid = 1'b0;
    tick();

    // reset mid-WAIT abandons the read
    fetch_req = 1'b1;
    pc_in     = 16'h0ABC;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    chk("mw_state", 32'(state_dbg), 32'(ST_WAIT));
    reset_n = 1'b0;
    #1;
    chk("mw_ir_out",    32'(ir_out),    32'd0);
    chk("mw_mem_addr",  32'(mem_addr),  32'd0);
    chk("mw_rd_en",     32'(mem_rd_en), 32'd0);
    chk("mw_busy",      32'(busy),      32'd0);
    chk("mw_ir_valid",  32'(ir_valid),  32'd0);
    chk("mw_fetch_err", 32'(fetch_err), 32'd0);
    chk("mw_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    reset_n    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("post_rst_ir_out",   32'(ir_out),   32'h0000);
    chk("post_rst_ir_valid", 32'(ir_valid), 32'd0);
    mem_rvalid = 1'b0;
    tick();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
